keccak_theta_stream: RTL

- Lane-serial, width-parametrised Keccak-p theta step engine for the permutation datapath.
- Accepts 25 lanes over a valid/ready stream and accumulates the column parities.
- Computes D once, then streams out the 25 theta-mixed lanes in the same order.
- Supports Keccak-p[b] for b = 25*LANE_W (200..1600), trading area for latency against the fully combinational theta.

---
 rtl/keccak_theta_stream_if.sv | 15 +
 rtl/keccak_theta_stream.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/keccak_theta_stream_if.sv
// Lane stream bundle for the theta engine: one lane per valid/ready handshake,
// with last marking lane 24 of a 25-lane Keccak state.
interface keccak_theta_stream_if #(
  parameter int LANE_W = 64
);
  // Handshake: a lane transfers on a rising clk edge where valid and ready are
  // both high; the master holds lane/last stable while valid is high and ready is low.
  logic              valid;
  logic              ready;
  logic [LANE_W-1:0] lane;
  logic              last;

  modport master (output valid, output lane, output last, input ready);
  modport slave  (input valid, input lane, input last, output ready);
endinterface

// File: rtl/keccak_theta_stream.sv
// Lane-serial Keccak-p theta step: load 25 lanes, compute D once, stream out theta-mixed lanes.
// Optional column-parity debug tap enabled by defining KECCAK_THETA_PARITY_OUT_EN.
module keccak_theta_stream #(
  parameter int LANE_W = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  keccak_theta_stream_if.slave         in_s,
  keccak_theta_stream_if.master        out_s,
  output logic                         busy,
  output logic                         err_last,
`ifdef KECCAK_THETA_PARITY_OUT_EN
  output logic [5*LANE_W-1:0]          col_par,
  output logic                         col_par_valid,
`endif
  output logic [1:0]                   dbg_state
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_CALC  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [2:0]        x;
  logic [2:0]        y;
  logic [4:0]        idx;
  logic              at_last;
  logic              in_hs;
  logic              out_hs;
  logic [LANE_W-1:0] c [5];
  logic [LANE_W-1:0] d [5];
  logic [LANE_W-1:0] lane_mem [25];
  logic              in_ready_r;
  logic              out_valid_r;
  logic              out_last_r;
  logic              busy_r;
  logic              err_last_r;

  function automatic logic [LANE_W-1:0] rol1(input logic [LANE_W-1:0] v);
    return {v[LANE_W-2:0], v[LANE_W-1]};
  endfunction

  // The lane counter is kept as (x, y) so the column select needs no divide.
  assign idx     = {x, 2'b00} + {2'b00, x} + {2'b00, y};
  assign at_last = (x == 3'd4) && (y == 3'd4);
  assign in_hs   = in_ready_r & in_s.valid;
  assign out_hs  = out_valid_r & out_s.ready;

  assign in_s.ready  = in_ready_r;
  assign out_s.valid = out_valid_r;
  assign out_s.last  = out_last_r;
  assign out_s.lane  = lane_mem[idx] ^ d[x];
  assign busy        = busy_r;
  assign err_last    = err_last_r;
  assign dbg_state   = state;

`ifdef KECCAK_THETA_PARITY_OUT_EN
  for (genvar k = 0; k < 5; k++) begin : g_col_par
    assign col_par[k*LANE_W +: LANE_W] = c[k];
  end
  assign col_par_valid = (state != S_LOAD);
`endif

  // Lane buffer contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (in_hs) lane_mem[idx] <= in_s.lane;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_LOAD;
      x           <= 3'd0;
      y           <= 3'd0;
      c           <= '{default: '0};
      d           <= '{default: '0};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      err_last_r  <= 1'b0;
    end else begin
      err_last_r <= 1'b0;
      case (state)
        S_LOAD: begin
          if (in_hs) begin
            c[x]       <= c[x] ^ in_s.lane;
            err_last_r <= (in_s.last != at_last);
            busy_r     <= 1'b1;
            if (at_last) begin
              x          <= 3'd0;
              y          <= 3'd0;
              in_ready_r <= 1'b0;
              state      <= S_CALC;
            end else if (y == 3'd4) begin
              y <= 3'd0;
              x <= x + 3'd1;
            end else begin
              y <= y + 3'd1;
            end
          end
        end
        S_CALC: begin
          d[0]        <= c[4] ^ rol1(c[1]);
          d[1]        <= c[0] ^ rol1(c[2]);
          d[2]        <= c[1] ^ rol1(c[3]);
          d[3]        <= c[2] ^ rol1(c[4]);
          d[4]        <= c[3] ^ rol1(c[0]);
          out_valid_r <= 1'b1;
          out_last_r  <= 1'b0;
          state       <= S_DRAIN;
        end
        S_DRAIN: begin
          if (out_hs) begin
            if (at_last) begin
              x           <= 3'd0;
              y           <= 3'd0;
              c           <= '{default: '0};
              in_ready_r  <= 1'b1;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              busy_r      <= 1'b0;
              state       <= S_LOAD;
            end else begin
              // Registered out_last must be high for the lane about to be presented.
              out_last_r <= (x == 3'd4) && (y == 3'd3);
              if (y == 3'd4) begin
                y <= 3'd0;
                x <= x + 3'd1;
              end else begin
                y <= y + 3'd1;
              end
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule
